// File: rtl/e_mdu_ctrl_if.sv
// e_mdu_ctrl_if: E-stage multiply/divide unit request and result bundle.
interface e_mdu_ctrl_if;
    logic [3:0]  MDUOp;
    logic        Start;
    logic [31:0] MDUIn1;
    logic [31:0] MDUIn2;
    logic        Req;
    logic        Busy;
    logic [31:0] MDURes;
    modport master(output MDUOp, Start, MDUIn1, MDUIn2, Req, input Busy, MDURes);
    modport slave(input MDUOp, Start, MDUIn1, MDUIn2, Req, output Busy, MDURes);
endinterface

// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: fixed-latency mult/div sequencer owning HI/LO, with mt*/mf* access and flush protection.
module e_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic clk,
    input logic reset,
    e_mdu_ctrl_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state;
    logic        busy;
    logic        wr_pend;
    logic [3:0]  cnt;
    logic [31:0] hi, lo, hi_next, lo_next;
    logic        start_ok, is_div, signed_op, neg_a, neg_b, div_zero;
    logic [31:0] ua, ub, uq, ur, div_q, div_r;
    logic [63:0] a64, b64, prod;
    always_comb begin
        start_ok  = bus.Start && !bus.Req && bus.MDUOp >= 4'd1 && bus.MDUOp <= 4'd4;
        is_div    = bus.MDUOp == 4'd3 || bus.MDUOp == 4'd4;
        signed_op = bus.MDUOp == 4'd1 || bus.MDUOp == 4'd3;
        neg_a     = signed_op && bus.MDUIn1[31];
        neg_b     = signed_op && bus.MDUIn2[31];
        // Sign-extending into 64 bits lets one unsigned multiplier serve both mult and multu.
        a64       = {{32{neg_a}}, bus.MDUIn1};
        b64       = {{32{neg_b}}, bus.MDUIn2};
        prod      = a64 * b64;
        // Magnitude division avoids the 0x80000000 / -1 overflow trap of native signed divide.
        ua        = neg_a ? -bus.MDUIn1 : bus.MDUIn1;
        ub        = neg_b ? -bus.MDUIn2 : bus.MDUIn2;
        div_zero  = bus.MDUIn2 == 32'd0;
        uq        = ua / (div_zero ? 32'd1 : ub);
        ur        = ua % (div_zero ? 32'd1 : ub);
        div_q     = (neg_a ^ neg_b) ? -uq : uq;
        div_r     = neg_a ? -ur : ur;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            wr_pend <= 1'b0;
            cnt     <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            hi_next <= 32'd0;
            lo_next <= 32'd0;
        end else if (state == IDLE) begin
            if (start_ok) begin
                state   <= RUN;
                busy    <= 1'b1;
                cnt     <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                hi_next <= is_div ? div_r : prod[63:32];
                lo_next <= is_div ? div_q : prod[31:0];
                wr_pend <= !(is_div && div_zero);
            end else if (!bus.Start && !bus.Req && bus.MDUOp == 4'd5) begin
                hi <= bus.MDUIn1;
            end else if (!bus.Start && !bus.Req && bus.MDUOp == 4'd6) begin
                lo <= bus.MDUIn1;
            end
        end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= 4'd0;
                if (wr_pend) begin
                    hi <= hi_next;
                    lo <= lo_next;
                end
            end
        end
    end
    assign bus.Busy   = busy;
    assign bus.MDURes = bus.MDUOp == 4'd7 ? hi : bus.MDUOp == 4'd8 ? lo : 32'd0;
endmodule
